// File: rtl/signext_arbiter_pkg.sv
// Shared types and constants for the sign-expander arbiter.
// Owner encoding is local to this block; SEop codes stay opaque.
package signext_arbiter_pkg;

    localparam int OP_W    = 3;
    localparam int FIELD_W = 26;
    localparam int RES_W   = 32;

    localparam int              MEM_STREAK_DEF = 4;
    // Unsigned-byte SEop: a harmless op for an idle expander.
    localparam logic [OP_W-1:0] IDLE_OP_DEF    = 3'b001;

    typedef enum logic {
        OWNER_ID  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    typedef struct packed {
        logic                valid;
        owner_e              owner;
        logic [OP_W-1:0]     op;
        logic [FIELD_W-1:0]  field;
    } stage_t;

    // A requester may be accepted only if its result slot will be empty
    // and it does not already own the op currently in the stage register.
    function automatic logic slot_free(input logic   rvalid,
                                       input logic   rready,
                                       input stage_t stage,
                                       input owner_e who);
        return (!rvalid || rready) && !(stage.valid && stage.owner == who);
    endfunction

endpackage

// File: rtl/signext_rr_pick.sv
// Grant selection between decode and memory requesters, with a bounded
// memory-stage streak so a pending decode request cannot starve.
module signext_rr_pick
    import signext_arbiter_pkg::*;
#(
    parameter int MEM_STREAK = MEM_STREAK_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic id_elig_i,
    input  logic mem_elig_i,
    input  logic id_req_i,
    output logic id_grant_o,
    output logic mem_grant_o
);

    localparam int             SW         = $clog2(MEM_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MEM_STREAK);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    always_comb begin
        id_grant_o  = 1'b0;
        mem_grant_o = 1'b0;
        if (id_elig_i && mem_elig_i) begin
            if (streak_q == STREAK_MAX) id_grant_o  = 1'b1;
            else                        mem_grant_o = 1'b1;
        end else if (id_elig_i) begin
            id_grant_o = 1'b1;
        end else if (mem_elig_i) begin
            mem_grant_o = 1'b1;
        end
    end

    // Holds across no-grant cycles so blocked cycles do not reset fairness.
    always_comb begin
        streak_d = streak_q;
        if (id_grant_o || !id_req_i) begin
            streak_d = '0;
        end else if (mem_grant_o && streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) streak_q <= '0;
        else       streak_q <= streak_d;
    end

endmodule

// File: rtl/signext_arbiter.sv
// Shares one combinational sign expander between decode and memory stages:
// arbitrate, register the winner, expand next cycle, buffer per requester.
module signext_arbiter
    import signext_arbiter_pkg::*;
#(
    parameter int              MEM_STREAK = MEM_STREAK_DEF,
    parameter logic [OP_W-1:0] IDLE_OP    = IDLE_OP_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               id_req_i,
    input  logic [OP_W-1:0]    id_op_i,
    input  logic [FIELD_W-1:0] id_field_i,
    output logic               id_ack_o,
    output logic               id_rvalid_o,
    output logic [RES_W-1:0]   id_result_o,
    input  logic               id_rready_i,
    input  logic               mem_req_i,
    input  logic [OP_W-1:0]    mem_op_i,
    input  logic [FIELD_W-1:0] mem_field_i,
    output logic               mem_ack_o,
    output logic               mem_rvalid_o,
    output logic [RES_W-1:0]   mem_result_o,
    input  logic               mem_rready_i,
    output logic [7:0]         se_imm8_o,
    output logic [15:0]        se_imm16_o,
    output logic [FIELD_W-1:0] se_imm26_o,
    output logic [OP_W-1:0]    se_op_o,
    input  logic [RES_W-1:0]   se_out32_i
);

    localparam stage_t STAGE_RST = '{valid: 1'b0, owner: OWNER_ID, op: IDLE_OP, field: '0};

    stage_t             stage_q, stage_d;
    logic               id_rvalid_q, id_rvalid_d;
    logic [RES_W-1:0]   id_result_q, id_result_d;
    logic               mem_rvalid_q, mem_rvalid_d;
    logic [RES_W-1:0]   mem_result_q, mem_result_d;
    logic               id_elig, mem_elig;
    logic [FIELD_W-1:0] se_field;

    assign id_elig  = !rst_i && id_req_i
                      && slot_free(id_rvalid_q, id_rready_i, stage_q, OWNER_ID);
    assign mem_elig = !rst_i && mem_req_i
                      && slot_free(mem_rvalid_q, mem_rready_i, stage_q, OWNER_MEM);

    signext_rr_pick #(.MEM_STREAK(MEM_STREAK)) u_pick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .id_elig_i   (id_elig),
        .mem_elig_i  (mem_elig),
        .id_req_i    (id_req_i),
        .id_grant_o  (id_ack_o),
        .mem_grant_o (mem_ack_o)
    );

    always_comb begin
        stage_d       = stage_q;
        stage_d.valid = 1'b0;
        if (id_ack_o) begin
            stage_d = '{valid: 1'b1, owner: OWNER_ID, op: id_op_i, field: id_field_i};
        end else if (mem_ack_o) begin
            stage_d = '{valid: 1'b1, owner: OWNER_MEM, op: mem_op_i, field: mem_field_i};
        end
    end

    // An empty stage drives a quiet expander rather than the stale op.
    assign se_op_o    = stage_q.valid ? stage_q.op : IDLE_OP;
    assign se_field   = stage_q.valid ? stage_q.field : '0;
    assign se_imm8_o  = se_field[7:0];
    assign se_imm16_o = se_field[15:0];
    assign se_imm26_o = se_field;

    // A same-edge write wins over a drain, keeping rvalid high.
    always_comb begin
        id_rvalid_d  = id_rvalid_q && !id_rready_i;
        id_result_d  = id_result_q;
        mem_rvalid_d = mem_rvalid_q && !mem_rready_i;
        mem_result_d = mem_result_q;
        if (stage_q.valid && stage_q.owner == OWNER_ID) begin
            id_rvalid_d = 1'b1;
            id_result_d = se_out32_i;
        end
        if (stage_q.valid && stage_q.owner == OWNER_MEM) begin
            mem_rvalid_d = 1'b1;
            mem_result_d = se_out32_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q      <= STAGE_RST;
            id_rvalid_q  <= 1'b0;
            id_result_q  <= '0;
            mem_rvalid_q <= 1'b0;
            mem_result_q <= '0;
        end else begin
            stage_q      <= stage_d;
            id_rvalid_q  <= id_rvalid_d;
            id_result_q  <= id_result_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_result_q <= mem_result_d;
        end
    end

    assign id_rvalid_o  = id_rvalid_q;
    assign id_result_o  = id_result_q;
    assign mem_rvalid_o = mem_rvalid_q;
    assign mem_result_o = mem_result_q;

endmodule
